// File: rtl/ws2812_chain.sv
// WS2812/SK6812 chain driver: double-buffered LED bank, global brightness
// scaling, and bit-exact serial timing followed by a latch gap.
module ws2812_chain #(
  parameter int unsigned CLK_MHZ   = 27,
  parameter int unsigned NUM_LEDS  = 16,
  parameter int unsigned BPL       = 24,
  parameter int unsigned T0H_NS    = 400,
  parameter int unsigned T1H_NS    = 800,
  parameter int unsigned PERIOD_NS = 1250,
  parameter int unsigned RESET_US  = 280,
  localparam int unsigned AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BPL-1:0] wr_data,
  input  logic [7:0]    brightness,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          data
);

  localparam int unsigned T0H   = CLK_MHZ * T0H_NS / 1000;
  localparam int unsigned T1H   = CLK_MHZ * T1H_NS / 1000;
  localparam int unsigned TP    = CLK_MHZ * PERIOD_NS / 1000;
  localparam int unsigned TR    = CLK_MHZ * RESET_US;
  localparam int unsigned CMAX  = (TR > TP) ? TR : TP;
  localparam int unsigned CW    = $clog2(CMAX + 1);
  localparam int unsigned BW    = $clog2(BPL);
  localparam int unsigned NB    = BPL / 8;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, LOAD, BIT, LATCH} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   bit_idx, bit_n;
  logic [AW-1:0]   led_idx, led_n;
  logic [BPL-1:0]  shreg, sh_n;
  logic            sel, sel_n;
  logic            pending, pend_n;
  logic [7:0]      bright, bright_n;
  logic            data_n, busy_n, done_n;
  logic [AW-1:0]   fetch_idx;
  logic [BPL-1:0]  rd_word;

  // Both banks in one array, bank select is the index MSB; never reset
  logic [BPL-1:0]  mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < NUM_LEDS))
      mem[{~sel, wr_addr}] <= wr_data;
  end

  assign fetch_idx = (state == LOAD) ? '0 : AW'(led_idx + 1'b1);
  assign rd_word   = mem[{sel, fetch_idx}];

  function automatic logic [BPL-1:0] scale(input logic [BPL-1:0] w, input logic [7:0] b);
    logic [15:0] p;
    scale = '0;
    for (int i = 0; i < NB; i++) begin
      p = 16'(w[i*8 +: 8]) * 16'({1'b0, b} + 9'd1);
      scale[i*8 +: 8] = 8'(p >> 8);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      led_idx <= '0;
      shreg   <= '0;
      sel     <= 1'b0;
      pending <= 1'b0;
      bright  <= '0;
      data    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      led_idx <= led_n;
      shreg   <= sh_n;
      sel     <= sel_n;
      pending <= pend_n;
      bright  <= bright_n;
      data    <= data_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    led_n    = led_idx;
    sh_n     = shreg;
    sel_n    = sel;
    pend_n   = pending;
    bright_n = bright;

    if (start && state != IDLE) pend_n = 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          state_n  = LOAD;
          sel_n    = ~sel;
          bright_n = brightness;
          led_n    = '0;
        end
      end
      LOAD: begin
        sh_n    = scale(rd_word, bright);
        cnt_n   = '0;
        bit_n   = '0;
        state_n = BIT;
      end
      BIT: begin
        if (cnt == CW'(TP - 1)) begin
          cnt_n = '0;
          if (bit_idx == BW'(BPL - 1)) begin
            bit_n = '0;
            if (led_idx == AW'(NUM_LEDS - 1)) begin
              state_n = LATCH;
            end else begin
              led_n = fetch_idx;
              sh_n  = scale(rd_word, bright);
            end
          end else begin
            bit_n = BW'(bit_idx + 1'b1);
            sh_n  = shreg << 1;
          end
        end else begin
          cnt_n = CW'(cnt + 1'b1);
        end
      end
      LATCH: begin
        if (cnt == CW'(TR - 1)) begin
          cnt_n = '0;
          // A request landing in this final cycle chains straight into the next frame
          if (pending || start) begin
            state_n  = LOAD;
            sel_n    = ~sel;
            bright_n = brightness;
            led_n    = '0;
            pend_n   = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = CW'(cnt + 1'b1);
        end
      end
      default: state_n = IDLE;
    endcase

    data_n = (state_n == BIT) && (cnt_n < (sh_n[BPL-1] ? CW'(T1H) : CW'(T0H)));
    busy_n = (state_n != IDLE);
    done_n = (state_n == LATCH) && (cnt_n == CW'(TR - 1));
  end

endmodule

// File: tb/tb_ws2812_chain.sv
// Bench for ws2812_chain at 20 MHz: serial monitor with a word scoreboard,
// table-driven frames, plus pending/back-buffer/reset/32-bit sequences.
module tb_ws2812_chain;

  localparam int TP    = 25;
  localparam int T1H   = 16;
  localparam int T0H   = 8;
  localparam int FRAME = 2 + 2 * 24 * TP + 5600 - 1;
  localparam int FRAME32 = 2 + 32 * TP + 5600 - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic [7:0]  brightness = 8'hFF;
  logic        start = 1'b0;
  logic        busy, done, data;

  logic        b_wr_en = 1'b0;
  logic [0:0]  b_wr_addr = '0;
  logic [31:0] b_wr_data = '0;
  logic [7:0]  b_brightness = 8'hFF;
  logic        b_start = 1'b0;
  logic        b_busy, b_done, b_data;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];

  ws2812_chain #(.CLK_MHZ(20), .NUM_LEDS(2), .BPL(24)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .brightness(brightness), .start(start), .busy(busy), .done(done), .data(data)
  );

  ws2812_chain #(.CLK_MHZ(20), .NUM_LEDS(1), .BPL(32)) dut32 (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .brightness(b_brightness), .start(b_start), .busy(b_busy), .done(b_done), .data(b_data)
  );

  always #5 clk = ~clk;

  initial begin
    #(300000 * 10);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Serial decoder: classifies each high pulse and assembles 24-bit words
  int          m_cyc = 0, m_hi = 0, m_nbits = 0, m_last = 0;
  bit          m_have = 0;
  logic        m_prev = 1'b0;
  logic [23:0] m_acc = '0;

  always @(negedge clk) begin
    m_cyc++;
    if (rst) begin
      m_hi = 0; m_prev = 1'b0; m_nbits = 0; m_acc = '0; m_have = 0;
    end else begin
      if (data && !m_prev) begin
        if (m_have && (m_cyc - m_last) < 2 * TP) chk("bit_period", m_cyc - m_last, TP);
        m_last = m_cyc; m_have = 1; m_hi = 0;
      end
      if (data) m_hi++;
      else if (m_prev) begin
        chk("pulse_width_valid", 32'(m_hi == T1H || m_hi == T0H), 1);
        m_acc = {m_acc[22:0], m_hi == T1H};
        m_nbits++;
        if (m_nbits == 24) begin
          m_nbits = 0;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL led_word got=%0h want=none_queued", m_acc);
          end else chk("led_word", m_acc, exp_q.pop_front());
        end
      end
      m_prev = data;
    end
  end

  task automatic wr(input logic a, input logic [23:0] d);
    @(posedge clk); #1 wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int lim, output int n);
    n = n0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic [23:0] e0, input logic [23:0] e1,
                           input bit scramble);
    int n;
    brightness = b;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    pulse_start();
    @(negedge clk);
    chk("busy_k1", busy, 1);
    chk("data_k1", data, 0);
    if (scramble) brightness = ~b;
    @(negedge clk);
    chk("data_k2", data, 1);
    wait_done(2, FRAME + 100, n);
    chk("done_latency", n, FRAME);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  typedef struct {
    logic [7:0]  b;
    logic [23:0] l0, l1, e0, e1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n, hi, ndone;
    logic [31:0] w32;

    vecs[0] = '{8'hFF, 24'hFF0000, 24'h00000F, 24'hFF0000, 24'h00000F};
    vecs[1] = '{8'd127, 24'h808080, 24'h808080, 24'h404040, 24'h404040};
    vecs[2] = '{8'h00, 24'h123456, 24'hABCDEF, 24'h000000, 24'h000000};
    vecs[3] = '{8'd128, 24'hFFFFFF, 24'h010203, 24'h808080, 24'h000101};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_busy32", b_busy, 0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (vecs[i]) begin
      wr(1'b0, vecs[i].l0);
      wr(1'b1, vecs[i].l1);
      run_frame(vecs[i].b, vecs[i].e0, vecs[i].e1, 1'b1);
    end

    // One pending request during frame A, a second one dropped; back-bank writes mid-frame
    brightness = 8'hFF;
    wr(1'b0, 24'hA5A55A);
    wr(1'b1, 24'h3C0FF0);
    exp_q.push_back(24'hA5A55A);
    exp_q.push_back(24'h3C0FF0);
    pulse_start();
    repeat (300) @(posedge clk);
    wr(1'b0, 24'h0000FF);
    wr(1'b1, 24'h123456);
    exp_q.push_back(24'h0000FF);
    exp_q.push_back(24'h123456);
    pulse_start();
    repeat (100) @(posedge clk);
    pulse_start();
    wait_done(0, FRAME + 100, n);
    chk("pend_done1_seen", done, 1);
    @(negedge clk);
    chk("pend_busy_reload", busy, 1);
    chk("pend_done1_width", done, 0);
    wait_done(1, FRAME + 100, n);
    chk("pend_done2_latency", n, FRAME);
    @(negedge clk);
    chk("pend_idle_after", busy, 0);
    repeat (20) @(negedge clk);
    chk("pend_no_third", busy, 0);

    // Back bank now holds frame A; only LED1 is rewritten
    wr(1'b1, 24'h112233);
    run_frame(8'hFF, 24'hA5A55A, 24'h112233, 1'b0);

    // Reset during bit 10 aborts the frame without a done pulse
    wr(1'b0, 24'hFFFFFF);
    wr(1'b1, 24'h000000);
    pulse_start();
    repeat (255) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_data", data, 0);
    chk("rst_mid_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("rst_mid_no_done", ndone, 0);
    chk("rst_mid_words_left", exp_q.size(), 0);
    wr(1'b0, 24'h00FF00);
    wr(1'b1, 24'hF00001);
    run_frame(8'hFF, 24'h00FF00, 24'hF00001, 1'b0);

    // 32-bit words; out-of-range address must not land anywhere visible
    @(posedge clk); #1 b_wr_en = 1'b1; b_wr_addr = 1'b0; b_wr_data = 32'h000000FF;
    @(posedge clk); #1 b_wr_addr = 1'b1; b_wr_data = 32'hFFFFFFFF;
    @(posedge clk); #1 b_wr_en = 1'b0;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    @(negedge clk);
    chk("b32_busy_k1", b_busy, 1);
    w32 = 32'h000000FF;
    n = 1;
    for (int i = 0; i < 32; i++) begin
      hi = 0;
      repeat (TP) begin
        @(negedge clk); n++;
        if (b_data === 1'b1) hi++;
      end
      chk($sformatf("b32_bit%0d_high", i), hi, w32[31-i] ? T1H : T0H);
    end
    while (b_done !== 1'b1 && n < FRAME32 + 100) begin
      @(negedge clk); n++;
    end
    chk("b32_done_latency", n, FRAME32);
    @(negedge clk);
    chk("b32_busy_after", b_busy, 0);

    chk("words_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
